// File: rtl/wb_conbus_param.sv
// Parameterised Wishbone shared-bus interconnect: NM masters arbitrate for one
// bus, address-decoded onto NS slaves, with a watchdog for stalled transfers.
module wb_conbus_param #(
    parameter int NM       = 4,
    parameter int NS       = 4,
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int ARB_MODE = 1,
    parameter int TIMEOUT  = 255,
    parameter int SW       = DW / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_cab_i,
    output logic [NM*DW-1:0] m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_rty_o,
    output logic [NS*DW-1:0] s_dat_o,
    output logic [NS*AW-1:0] s_adr_o,
    output logic [NS*SW-1:0] s_sel_o,
    output logic [NS-1:0]    s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    output logic [NS-1:0]    s_cab_o,
    input  logic [NS*DW-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS-1:0]    s_err_i,
    input  logic [NS-1:0]    s_rty_i,
    output logic [NM-1:0]    gnt_o,
    output logic             tmo_o
);
    localparam int   MW    = (NM > 1) ? $clog2(NM) : 1;
    localparam logic WD_EN = (TIMEOUT != 0);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [NM-1:0]   gnt_r, gnt_s;
    logic [MW-1:0]   gidx_r, gidx_s, ptr_r, ptr_s;
    logic [7:0]      wd_cnt_r, wd_cnt_s;
    logic            found_s, hit_s;
    int              cand_s;

    logic            g_cyc_s, g_stb_s, g_we_s, g_cab_s;
    logic [AW-1:0]   g_adr_s;
    logic [DW-1:0]   g_dat_s, r_dat_s;
    logic [SW-1:0]   g_sel_s;
    logic [2:0]      sidx_s;
    logic            mapped_s, unmapped_s, resp_s, stall_s, expire_s;
    logic            r_ack_s, r_err_s, r_rty_s;

    // Granted master's request; cyc/stb only count while the bus is owned
    assign g_cyc_s = (state_r == BUSY) & m_cyc_i[gidx_r];
    assign g_stb_s = g_cyc_s & m_stb_i[gidx_r];
    assign g_we_s  = m_we_i[gidx_r];
    assign g_cab_s = m_cab_i[gidx_r];
    assign g_adr_s = m_adr_i[gidx_r*AW +: AW];
    assign g_dat_s = m_dat_i[gidx_r*DW +: DW];
    assign g_sel_s = m_sel_i[gidx_r*SW +: SW];

    assign sidx_s     = g_adr_s[AW-1 -: 3];
    assign mapped_s   = (32'(sidx_s) < 32'(NS));
    assign unmapped_s = g_stb_s & ~mapped_s;

    // Response from a slave or the decoder beats a pending watchdog expiry
    assign resp_s   = (g_cyc_s & (r_ack_s | r_err_s | r_rty_s)) | unmapped_s;
    assign stall_s  = g_stb_s & ~resp_s;
    assign expire_s = WD_EN & stall_s & (wd_cnt_r == 8'(TIMEOUT));

    // Arbitration and ownership next-state
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        gidx_s  = gidx_r;
        ptr_s   = ptr_r;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        case (state_r)
            IDLE: begin
                for (int k = 1; k <= NM; k++) begin
                    cand_s  = (ARB_MODE == 1) ? ((int'(ptr_r) + k) % NM) : (k - 1);
                    hit_s   = !found_s && m_cyc_i[cand_s];
                    gidx_s  = hit_s ? MW'(cand_s) : gidx_s;
                    found_s = found_s | hit_s;
                end
                if (found_s) begin
                    state_s        = BUSY;
                    gnt_s          = {NM{1'b0}};
                    gnt_s[gidx_s]  = 1'b1;
                    ptr_s          = (ARB_MODE == 1) ? gidx_s : ptr_r;
                end else begin
                    gnt_s = {NM{1'b0}};
                end
            end
            BUSY: begin
                if (!m_cyc_i[gidx_r]) begin
                    state_s = IDLE;
                    gnt_s   = {NM{1'b0}};
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {NM{1'b0}};
            end
        endcase
    end

    // Watchdog counts consecutive unanswered strobe cycles of the owner
    always_comb begin
        if (stall_s && !expire_s && WD_EN) begin
            wd_cnt_s = wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_s = 8'd0;
        end
    end

    // State, grant, round-robin pointer and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            gnt_r    <= {NM{1'b0}};
            gidx_r   <= {MW{1'b0}};
            ptr_r    <= MW'(NM - 1);
            wd_cnt_r <= 8'd0;
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            gidx_r   <= gidx_s;
            ptr_r    <= ptr_s;
            wd_cnt_r <= wd_cnt_s;
        end
    end

    // Address decode: strobe and return path only through the selected slave
    always_comb begin
        s_stb_o = {NS{1'b0}};
        r_ack_s = 1'b0;
        r_err_s = 1'b0;
        r_rty_s = 1'b0;
        r_dat_s = {DW{1'b0}};
        if (mapped_s) begin
            s_stb_o[sidx_s] = g_stb_s;
            r_ack_s         = s_ack_i[sidx_s];
            r_err_s         = s_err_i[sidx_s];
            r_rty_s         = s_rty_i[sidx_s];
            r_dat_s         = s_dat_i[sidx_s*DW +: DW];
        end else begin
            s_stb_o = {NS{1'b0}};
        end
    end

    assign s_cyc_o = {NS{g_cyc_s}};
    assign s_we_o  = {NS{g_we_s}};
    assign s_cab_o = {NS{g_cab_s}};
    assign s_adr_o = {NS{g_adr_s}};
    assign s_dat_o = {NS{g_dat_s}};
    assign s_sel_o = {NS{g_sel_s}};

    // Responses reach only the owning master; read data is broadcast
    always_comb begin
        m_ack_o         = {NM{1'b0}};
        m_err_o         = {NM{1'b0}};
        m_rty_o         = {NM{1'b0}};
        m_ack_o[gidx_r] = g_cyc_s & r_ack_s;
        m_err_o[gidx_r] = (g_cyc_s & r_err_s) | unmapped_s | expire_s;
        m_rty_o[gidx_r] = g_cyc_s & r_rty_s;
    end

    assign m_dat_o = {NM{r_dat_s}};
    assign gnt_o   = gnt_r;
    assign tmo_o   = expire_s;
endmodule

// File: tb/tb_wb_conbus_param.sv
// Bench for wb_conbus_param: directed arbitration/decode/watchdog/reset cases,
// then randomized rounds scored against a transaction-level reference queue.
module tb_wb_conbus_param;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] m_dat_i, m_adr_i, m_dat_o, s_dat_o, s_adr_o, s_dat_i;
    logic [15:0]  m_sel_i, s_sel_o;
    logic [3:0]   m_we_i, m_cyc_i, m_stb_i, m_cab_i, m_ack_o, m_err_o, m_rty_o;
    logic [3:0]   s_we_o, s_cyc_o, s_stb_o, s_cab_o, s_ack_i, s_err_i, s_rty_i;
    logic [3:0]   gnt_o;
    logic         tmo_o;

    logic [127:0] f_m_dat_o, f_s_dat_o, f_s_adr_o;
    logic [15:0]  f_s_sel_o;
    logic [3:0]   f_m_ack_o, f_m_err_o, f_m_rty_o, f_s_we_o, f_s_cyc_o, f_s_stb_o, f_s_cab_o;
    logic [3:0]   f_gnt_o;
    logic         f_tmo_o;

    typedef struct {
        int          mi;
        bit          err;
        bit          tmo;
        logic [31:0] rdata;
        logic [31:0] wdata;
        bit          we;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 1'b0;
    int   rsp_cnt = 0;

    always #5 clk = ~clk;

    wb_conbus_param #(.NM(4), .NS(4), .DW(32), .AW(32), .ARB_MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cab_i(m_cab_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cab_o(s_cab_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .tmo_o(tmo_o)
    );

    // Fixed-priority instance shares the master stimulus; its slaves stay silent
    wb_conbus_param #(.NM(4), .NS(4), .DW(32), .AW(32), .ARB_MODE(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst(rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cab_i(m_cab_i),
        .m_dat_o(f_m_dat_o), .m_ack_o(f_m_ack_o), .m_err_o(f_m_err_o), .m_rty_o(f_m_rty_o),
        .s_dat_o(f_s_dat_o), .s_adr_o(f_s_adr_o), .s_sel_o(f_s_sel_o), .s_we_o(f_s_we_o),
        .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o), .s_cab_o(f_s_cab_o),
        .s_dat_i(128'd0), .s_ack_i(4'd0), .s_err_i(4'd0), .s_rty_i(4'd0),
        .gnt_o(f_gnt_o), .tmo_o(f_tmo_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Slave model: acks after adr[1:0] strobe cycles with data {A5A5, adr[15:0]};
    // slave 3 with adr[2] set never answers. Unselected slaves drive noise.
    initial begin
        logic [31:0] a;
        s_ack_i = 4'd0; s_err_i = 4'd0; s_rty_i = 4'd0; s_dat_i = 128'd0;
        forever begin
            @(posedge clk); #2;
            s_ack_i = 4'd0;
            s_dat_i = {$urandom, $urandom, $urandom, $urandom};
            a = s_adr_o[31:0];
            if (s_stb_o != 4'd0) begin
                for (int s = 0; s < 4; s++) begin
                    if (s_stb_o[s]) begin
                        s_dat_i[s*32 +: 32] = {16'hA5A5, a[15:0]};
                        if (!(s == 3 && a[2]) && rsp_cnt == int'(a[1:0])) s_ack_i[s] = 1'b1;
                    end
                end
                rsp_cnt++;
            end else begin
                rsp_cnt = 0;
            end
        end
    end

    // Monitor: every master response consumes the oldest expected transaction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on && ((m_ack_o | m_err_o) != 4'd0)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", {60'd0, m_ack_o | m_err_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_master", {60'd0, m_ack_o | m_err_o}, 64'd1 << e.mi);
                    chk("sb_gnt", {60'd0, gnt_o}, 64'd1 << e.mi);
                    chk("sb_kind", {61'd0, m_ack_o[e.mi], m_err_o[e.mi], tmo_o},
                        {61'd0, !e.err, e.err, e.tmo});
                    if (!e.err) chk("sb_rdata", {32'd0, m_dat_o[e.mi*32 +: 32]}, {32'd0, e.rdata});
                    chk("sb_wdata", {32'd0, s_dat_o[127:96]}, {32'd0, e.wdata});
                    chk("sb_we", {60'd0, s_we_o}, {60'd0, {4{e.we}}});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=hang required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        exp_t        e;
        logic [3:0]  mask, pend;
        logic [31:0] a;
        int          pm, idx, last;

        rst = 1'b0;
        m_dat_i = 128'd0; m_sel_i = 16'd0; m_we_i = 4'd0; m_cab_i = 4'd0;
        m_adr_i = {4{32'hA000_0000}};
        m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {59'd0, gnt_o, tmo_o}, 64'd0);
        chk("rst_slave", {56'd0, s_stb_o, s_cyc_o}, 64'd0);
        chk("rst_master", {52'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
        chk("rst_fp_gnt", {60'd0, f_gnt_o}, 64'd0);
        m_cyc_i = 4'd0; m_stb_i = 4'd0; m_adr_i = 128'd0;
        @(posedge clk); #1 rst = 1'b1;

        // Fixed priority: masters 1 and 3 together
        @(posedge clk); #1 m_cyc_i = 4'b1010;
        @(negedge clk); chk("fp_latency", {60'd0, f_gnt_o}, 64'd0);
        @(negedge clk); chk("fp_first", {60'd0, f_gnt_o}, 64'b0010);
        chk("rr_first", {60'd0, gnt_o}, 64'b0010);
        repeat (2) @(negedge clk);
        chk("fp_hold", {60'd0, f_gnt_o}, 64'b0010);
        @(posedge clk); #1 m_cyc_i = 4'b1000;
        @(negedge clk); chk("fp_release", {60'd0, f_gnt_o}, 64'b0010);
        @(negedge clk); chk("fp_idle_gap", {60'd0, f_gnt_o}, 64'd0);
        @(negedge clk); chk("fp_second", {60'd0, f_gnt_o}, 64'b1000);
        @(posedge clk); #1 m_cyc_i = 4'd0;
        repeat (2) @(posedge clk);

        // Decode to slave 2 and routed read data
        #1;
        m_adr_i[95:64] = 32'h4000_0001; m_dat_i[95:64] = 32'h1234_5678;
        m_we_i = 4'b0100; m_sel_i[11:8] = 4'hF; m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("dec_gnt", {60'd0, gnt_o}, 64'b0100);
        chk("dec_stb", {60'd0, s_stb_o}, 64'b0100);
        chk("dec_bcast", {20'd0, s_dat_o[31:0], s_we_o, s_cyc_o, s_sel_o[3:0]},
            {20'd0, 32'h1234_5678, 4'hF, 4'hF, 4'hF});
        chk("dec_noack", {60'd0, m_ack_o}, 64'd0);
        @(negedge clk);
        chk("dec_ack", {60'd0, m_ack_o}, 64'b0100);
        chk("dec_rdata", {m_dat_o[95:64], m_dat_o[31:0]}, {32'hA5A5_0001, 32'hA5A5_0001});
        @(posedge clk); #1 m_cyc_i = 4'd0; m_stb_i = 4'd0; m_we_i = 4'd0;
        repeat (2) @(posedge clk);

        // Unmapped slave 5
        #1 m_adr_i[31:0] = 32'hA000_0000; m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("unmap_gnt", {60'd0, gnt_o}, 64'b0001);
        chk("unmap_stb", {60'd0, s_stb_o}, 64'd0);
        chk("unmap_err", {60'd0, m_err_o}, 64'b0001);
        @(posedge clk); #1 m_cyc_i = 4'd0; m_stb_i = 4'd0;
        repeat (2) @(posedge clk);

        // Watchdog with TIMEOUT = 8 on a silent slave
        #1 m_adr_i[63:32] = 32'h6000_0004; m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("wd_quiet", {59'd0, m_err_o, tmo_o}, 64'd0);
        end
        @(negedge clk);
        chk("wd_expire", {55'd0, m_err_o, tmo_o, gnt_o}, {55'd0, 4'b0010, 1'b1, 4'b0010});
        @(negedge clk);
        chk("wd_after", {55'd0, m_err_o, tmo_o, gnt_o}, {55'd0, 4'b0000, 1'b0, 4'b0010});
        @(posedge clk); #1 m_cyc_i = 4'd0; m_stb_i = 4'd0;
        repeat (2) @(posedge clk);

        // Reset mid-transfer, then the 0/2 tie goes to master 0
        #1 m_adr_i[95:64] = 32'h6000_0004; m_adr_i[31:0] = 32'h0;
        m_cyc_i = 4'b0101; m_stb_i = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", {56'd0, gnt_o, s_stb_o}, {56'd0, 4'b0100, 4'b1000});
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("mid_rst", {52'd0, gnt_o, s_stb_o, s_cyc_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("post_rst_gnt", {60'd0, gnt_o}, 64'b0001);
        @(posedge clk); #1 m_cyc_i = 4'd0; m_stb_i = 4'd0;
        repeat (3) @(posedge clk);

        // Randomized rounds; round-robin order predicted from the last owner
        pm = 0;
        sb_on = 1'b1;
        for (int r = 0; r < 40; r++) begin
            #1;
            mask = 4'($urandom_range(15, 1));
            for (int m = 0; m < 4; m++) begin
                a = $urandom;
                a[31:29] = 3'($urandom_range(7, 0));
                m_adr_i[m*32 +: 32] = a;
                m_dat_i[m*32 +: 32] = $urandom;
                m_sel_i[m*4 +: 4]   = 4'($urandom);
                m_we_i[m]           = 1'($urandom);
            end
            last = pm;
            for (int k = 1; k <= 4; k++) begin
                idx = (pm + k) % 4;
                if (mask[idx]) begin
                    a       = m_adr_i[idx*32 +: 32];
                    e.mi    = idx;
                    e.tmo   = (a[31:29] == 3'd3) && a[2];
                    e.err   = (a[31:29] >= 3'd4) || e.tmo;
                    e.rdata = {16'hA5A5, a[15:0]};
                    e.wdata = m_dat_i[idx*32 +: 32];
                    e.we    = m_we_i[idx];
                    exp_q.push_back(e);
                    last = idx;
                end
            end
            pm = last;
            m_cyc_i = mask; m_stb_i = mask;
            pend = mask;
            for (int c = 0; c < 300 && pend != 4'd0; c++) begin
                @(negedge clk);
                pend = pend & ~(m_ack_o | m_err_o);
                @(posedge clk); #1;
                m_cyc_i = m_cyc_i & pend;
                m_stb_i = m_stb_i & pend;
            end
            chk("round_done", {60'd0, pend}, 64'd0);
            m_cyc_i = 4'd0; m_stb_i = 4'd0;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        sb_on = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_conbus_param.md
WB_CONBUS_PARAM -- requirements
Module: wb_conbus_param

Interface
REQ-001 The block SHALL have parameter NM, default 4, number of masters (1..8).
REQ-002 The block SHALL have parameter NS, default 4, number of slaves (1..8).
REQ-003 The block SHALL have parameters DW (default 32) and AW (default 32), data and address widths; SW = DW/8 select width.
REQ-004 The block SHALL have parameter ARB_MODE, default 1; 0 = fixed priority, 1 = round robin.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (8 bit); 0 disables the watchdog.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1, clock; rst in 1, asynchronous active-low reset.
REQ-007 Master ports: m_dat_i in NM*DW, m_adr_i in NM*AW, m_sel_i in NM*SW, m_we_i/m_cyc_i/m_stb_i/m_cab_i in NM each; m_dat_o out NM*DW, m_ack_o/m_err_o/m_rty_o out NM each.
REQ-008 Slave ports: s_dat_o out NS*DW, s_adr_o out NS*AW, s_sel_o out NS*SW, s_we_o/s_cyc_o/s_stb_o/s_cab_o out NS each; s_dat_i in NS*DW, s_ack_i/s_err_i/s_rty_i in NS each.
REQ-009 Status: gnt_o out NM, one-hot current grant (0 when idle); tmo_o out 1, one-cycle pulse on watchdog expiry.

Function
REQ-010 The block SHALL have a two-state FSM: IDLE, BUSY.
REQ-011 IDLE: if any m_cyc_i set, register grant to the selected master and go to BUSY next edge; grant latency = 1 cycle from cyc.
REQ-012 Fixed priority: lowest requesting index wins.
REQ-013 Round robin: search starts at (last granted + 1) mod NM, wrapping; pointer updates on each grant.
REQ-014 BUSY: grant held while the granted master's m_cyc_i = 1; other requests ignored.
REQ-015 BUSY and granted m_cyc_i = 0: return to IDLE, gnt_o = 0; new arbitration occurs in IDLE (one idle cycle between owners).
REQ-016 Decode: slave index = m_adr_i[AW-1:AW-3] of granted master; index >= NS is unmapped.
REQ-017 Granted master's adr/dat/sel/we/cab SHALL be broadcast combinationally to all slaves; s_cyc_o all = granted cyc.
REQ-018 s_stb_o SHALL be asserted only on the decoded slave, gated by granted cyc & stb; unmapped address drives no stb.
REQ-019 Decoded slave's dat/ack/err/rty SHALL be routed combinationally to the granted master only; non-granted masters see ack/err/rty = 0; m_dat_o is broadcast to all masters.
REQ-020 Unmapped access (granted cyc & stb): m_err_o of granted master = 1 combinationally, same cycle.
REQ-021 Watchdog: counter increments each BUSY cycle with granted stb = 1 and no ack/err/rty; clears on any response, stb = 0, or IDLE.
REQ-022 Counter reaching TIMEOUT: next cycle drives m_err_o = 1 to the granted master for exactly one cycle, pulses tmo_o, clears counter; grant retained.
REQ-023 Simultaneous slave response and expiry in one cycle: slave response wins, counter clears, no tmo_o.
REQ-024 NM = 1: arbitration degenerates to grant master 0; round-robin pointer unused.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, gnt_o = 0, counter = 0, tmo_o = 0, RR pointer = NM-1 (master 0 first after reset).
REQ-026 During reset every slave stb/cyc and master ack/err/rty SHALL be 0; reset mid-transfer drops the grant immediately.

Verification
REQ-027 Masters 1 and 3 raise cyc together, ARB_MODE = 0 -> gnt_o = 4'b0010 one cycle later; master 3 granted only after master 1 drops cyc plus one IDLE cycle.
REQ-028 ARB_MODE = 1, all four masters hold cyc, each releases after one ack -> grant order 0,1,2,3,0.
REQ-029 Granted master, adr top bits = 3'b010, stb = 1 -> s_stb_o = 4'b0100 only; slave 2 ack with dat 0xA5A5_0001 -> granted m_ack_o = 1, m_dat_o = 0xA5A5_0001.
REQ-030 NS = 4, adr top bits = 3'b101 -> no s_stb_o, m_err_o = 1 same cycle.
REQ-031 TIMEOUT = 8, slave never responds -> after 8 stalled cycles, one-cycle m_err_o and tmo_o; grant still held.
REQ-032 rst low mid-BUSY -> gnt_o = 0 and s_stb_o = 0 immediately; after release, master 0 wins a 0/2 tie in round-robin mode.
